// File: rtl/cmd_frame_parser_pkg.sv
// Shared types and constants for the UART command frame parser.
package cmd_frame_parser_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'h55;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TYPE    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        SEND    = 3'd5
    } state_t;

    // One beat of the cmd bus towards the router.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] len;
        logic       last;
        logic       valid;
    } cmd_beat_t;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload register file: synchronous write, combinational read.
module cmd_payload_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage write; contents need no reset since they are only read after being written.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_frame_parser.sv
// Frames the UART byte stream into checked command bursts for the router.
module cmd_frame_parser
    import cmd_frame_parser_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned MAX_PAYLOAD = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_uart_data,
    input  logic       i_uart_valid,
    output logic [7:0] o_cmd_data,
    output logic [7:0] o_cmd_len,
    output logic       o_cmd_last,
    output logic       o_cmd_valid,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    type_q, type_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    idx_q, idx_d;
    logic [8:0]    beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    cmd_beat_t     cmd_q, cmd_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;

    logic          in_frame;
    logic          timeout;
    logic          pbuf_we;
    logic [AW-1:0] pbuf_waddr;
    logic [AW-1:0] pbuf_raddr;
    logic [7:0]    pbuf_rdata;

    cmd_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_pbuf (
        .i_clk (i_clk),
        .we    (pbuf_we),
        .waddr (pbuf_waddr),
        .wdata (i_uart_data),
        .raddr (pbuf_raddr),
        .rdata (pbuf_rdata)
    );

    // State, datapath and registered output stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            type_q     <= '0;
            len_q      <= '0;
            chk_q      <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, checksum, timeout and burst generation.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        len_d      = len_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        tmo_d      = '0;
        cmd_d      = '0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        pbuf_we    = 1'b0;
        pbuf_waddr = AW'(idx_q);
        // Next beat n >= 2 carries buf[n-2], i.e. buf[beat_q-1].
        pbuf_raddr = AW'(beat_q - 9'd1);

        // Counter holds cycles since the last byte; the cycle after a strobe reads 1.
        in_frame = (state_q == TYPE) || (state_q == LEN) ||
                   (state_q == PAYLOAD) || (state_q == CHK);
        if (in_frame) begin
            tmo_d = i_uart_valid ? TW'(1) : tmo_q + TW'(1);
        end
        timeout = in_frame && !i_uart_valid && (tmo_q == TMO_LAST);

        if (timeout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_uart_valid && (i_uart_data == HEADER)) begin
                        state_d = TYPE;
                        chk_d   = '0;
                        idx_d   = '0;
                        tmo_d   = TW'(1);
                    end
                end
                TYPE: begin
                    if (i_uart_valid) begin
                        type_d  = i_uart_data;
                        chk_d   = i_uart_data;
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (i_uart_valid) begin
                        len_d = i_uart_data;
                        chk_d = chk_q + i_uart_data;
                        idx_d = '0;
                        if (32'(i_uart_data) > MAX_PAYLOAD) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = IDLE;
                        end else if (i_uart_data == 8'd0) begin
                            state_d = CHK;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_uart_valid) begin
                        pbuf_we = 1'b1;
                        chk_d   = chk_q + i_uart_data;
                        idx_d   = idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (i_uart_valid) begin
                        if (i_uart_data == chk_q) begin
                            state_d     = SEND;
                            beat_d      = '0;
                            cmd_d.valid = 1'b1;
                            cmd_d.data  = HEADER;
                            cmd_d.len   = len_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CHK;
                            state_d    = IDLE;
                        end
                    end
                end
                SEND: begin
                    // Input bytes are dropped here; beat_q is the beat currently on the bus.
                    if (beat_q == 9'(len_q) + 9'd1) begin
                        state_d = IDLE;
                    end else begin
                        beat_d      = beat_q + 9'd1;
                        cmd_d.valid = 1'b1;
                        cmd_d.len   = len_q;
                        cmd_d.data  = (beat_q == 9'd0) ? type_q : pbuf_rdata;
                        cmd_d.last  = (beat_d == 9'(len_q) + 9'd1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign o_cmd_data  = cmd_q.data;
    assign o_cmd_len   = cmd_q.len;
    assign o_cmd_last  = cmd_q.last;
    assign o_cmd_valid = cmd_q.valid;
    assign o_frame_err = err_q;
    assign o_err_code  = err_code_q;
    assign o_busy      = busy_q;

endmodule
